fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that consumes the branch unit's redirect (PcSel/BrPC). It owns the fetch PC register and drives a synchronous-read instruction memory with a fixed 1-cycle read latency. It delivers instructions, each tagged with its PC, to decode over a valid/ready handshake, and uses a one-entry skid buffer so backpressure never loses or duplicates an instruction. The id_pc it emits travels down the pipeline and becomes the branch unit's Cur_PC.

Parameters:
PC_W, 9, width of the PC and of the instruction-memory byte address
INS_W, 32, instruction word width

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
PcSel  input  1  redirect request from the branch unit (1 = branch taken)
BrPC  input  32  redirect target from the branch unit; only bits [PC_W-1:0] are used
imem_addr  output  PC_W  byte address to instruction memory; always equals fetch_pc
imem_en  output  1  read strobe; 1 = fetch issued this cycle
imem_rdata  input  INS_W  read data, valid the cycle after the matching imem_en
id_valid  output  1  output register holds an instruction
id_ready  input  1  decode accepts; a transfer occurs when id_valid && id_ready
id_instr  output  INS_W  instruction presented to decode
id_pc  output  PC_W  PC of id_instr

Behaviour:
- State: fetch_pc[PC_W-1:0], inflight, out_valid/out_instr/out_pc, skid_valid/skid_instr/skid_pc, inflight_pc.
- Reset (async, while reset==0): all state cleared. fetch_pc=0, imem_en=0, id_valid=0, id_instr=0, id_pc=0, skid and inflight empty. Reset asserted mid-operation takes effect immediately, regardless of PcSel or the handshake.
- Occupancy occ = out_valid + skid_valid + inflight. drain = out_valid && id_ready.
- Issue rule: imem_en = !PcSel && (occ - drain) < 2. This is combinational.
  - When imem_en=1: at the clock edge inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^PC_W, so wrap-around is allowed).
  - When imem_en=0 (and no redirect): inflight<=0.
- Return path: if inflight==1, imem_rdata is captured together with inflight_pc.
  - Order is always skid before new data.
  - If the output register is empty or draining: skid data, if present, goes to the output and new data goes to skid. Otherwise new data goes directly to the output.
  - If the output is held (valid and not ready): new data goes to skid.
  - The issue rule guarantees skid is never overwritten while valid.
- Latency: an issue in cycle k gives id_valid=1 in cycle k+2. Steady-state throughput is 1 instruction per cycle with id_ready=1.
- Redirect (PcSel=1): takes priority over issue and return.
  - At the edge: fetch_pc <= {BrPC[PC_W-1:2], 2'b00}; low two bits are forced to 0, upper bits truncated.
  - out_valid, skid_valid and inflight are cleared, so any returning data for the old stream is discarded.
  - imem_en=0 that cycle. The target is issued in the next cycle, if not redirected again.
  - A handshake completing in the redirect cycle counts as done; discarding that instruction is the downstream flush logic's job.
- Back-to-back redirects: each one overrides the previous; only the last target is fetched.
- id_valid, id_instr and id_pc are driven directly from the output register, with no combinational path from inputs. id_instr and id_pc hold their value while id_valid && !id_ready.

Test Plan:
1. Release reset, id_ready=1, memory returns word = address → id_valid first high 2 cycles after the first imem_en; id_pc = 0x000, 0x004, 0x008 on consecutive cycles, each with id_instr equal to its PC.
2. Steady stream, then id_ready=0 for 3 cycles at id_pc=0x010 → id_pc/id_instr hold 0x010; imem_en drops once occ=2; after release, 0x014, 0x018 follow with no gap, loss or duplicate.
3. Full pipeline, PcSel=1 with BrPC=0x00000040 → next-cycle imem_addr=0x040 and imem_en=1; the stale return is dropped; first post-redirect id_pc=0x040, 2 cycles after that issue.
4. PC_W=9, fetch_pc=0x1FC with an issue → fetch_pc becomes 0x000; id_pc sequence 0x1FC, 0x000.
5. BrPC=0x00000F0B → fetch target 0x108 (bits [1:0] cleared, bits above PC_W dropped). PcSel=1 in two consecutive cycles with 0x020 then 0x080 → only 0x080 is fetched.
6. Assert reset (0) mid-stream while PcSel=1 and id_ready=0 → id_valid=0, imem_en=0, imem_addr=0, id_pc=0 immediately without a clock edge. After release, the fetch sequence restarts at 0x000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues reads to a 1-cycle
// synchronous instruction memory and hands {instr, pc} to decode through an
// output register backed by a one-entry skid buffer.
module fetch_unit #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned INS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    output logic [PC_W-1:0]  imem_addr,
    output logic             imem_en,
    input  logic [INS_W-1:0] imem_rdata,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [INS_W-1:0] id_instr,
    output logic [PC_W-1:0]  id_pc
);

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic             out_valid_q, out_valid_d;
    logic [INS_W-1:0] out_instr_q, out_instr_d;
    logic [PC_W-1:0]  out_pc_q, out_pc_d;
    logic             skid_valid_q, skid_valid_d;
    logic [INS_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]  skid_pc_q, skid_pc_d;

    logic [1:0]       occ;
    logic [1:0]       load;
    logic             drain;
    logic             out_free;
    logic             issue;
    logic [PC_W-1:0]  redirect_pc;

    // Only the in-range, word-aligned part of the branch target is used.
    logic unused_br;
    assign unused_br   = ^{BrPC[31:PC_W], BrPC[1:0]};
    assign redirect_pc = {BrPC[PC_W-1:2], 2'b00};

    // Entries that would still be held after this cycle's drain; issuing only
    // while this is below 2 guarantees the returning word always has a slot.
    assign occ      = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(inflight_q);
    assign drain    = out_valid_q && id_ready;
    assign load     = occ - 2'(drain);
    assign out_free = !out_valid_q || id_ready;
    assign issue    = reset && !PcSel && (load < 2'd2);

    assign imem_en   = issue;
    assign imem_addr = fetch_pc_q;
    assign id_valid  = out_valid_q;
    assign id_instr  = out_instr_q;
    assign id_pc     = out_pc_q;

    // Next state: redirect flushes everything, otherwise issue and return.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;

        if (PcSel) begin
            fetch_pc_d   = redirect_pc;
            inflight_d   = 1'b0;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + PC_W'(3'd4);
            end else begin
                inflight_d = 1'b0;
            end

            if (out_free) begin
                if (skid_valid_q) begin
                    // Older skid entry goes out first; new word refills skid.
                    out_valid_d = 1'b1;
                    out_instr_d = skid_instr_q;
                    out_pc_d    = skid_pc_q;
                    if (inflight_q) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = inflight_pc_q;
                    end else begin
                        skid_valid_d = 1'b0;
                    end
                end else if (inflight_q) begin
                    out_valid_d = 1'b1;
                    out_instr_d = imem_rdata;
                    out_pc_d    = inflight_pc_q;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (inflight_q) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = inflight_pc_q;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model returns word == address, a scoreboard
// tracks issued PCs and checks every decode transfer, plus directed sequences.
module tb_fetch_unit;

    localparam int unsigned PC_W  = 9;
    localparam int unsigned INS_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             PcSel;
    logic [31:0]      BrPC;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_en;
    logic [INS_W-1:0] imem_rdata;
    logic             id_valid;
    logic             id_ready;
    logic [INS_W-1:0] id_instr;
    logic [PC_W-1:0]  id_pc;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.PC_W(PC_W), .INS_W(INS_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .PcSel      (PcSel),
        .BrPC       (BrPC),
        .imem_addr  (imem_addr),
        .imem_en    (imem_en),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; junk on idle cycles exposes bogus captures.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= {{(INS_W-PC_W){1'b0}}, imem_addr};
        else         imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard: model fetch PC, queue of issued PCs, pop on each transfer.
    logic [PC_W-1:0] exp_q[$];
    logic [PC_W-1:0] mfpc;
    logic [PC_W-1:0] head;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            mfpc = '0;
        end else begin
            if (id_valid && id_ready) begin
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    head = exp_q.pop_front();
                    check("sb_pc", 32'(id_pc), 32'(head));
                    check("sb_instr", id_instr, 32'(head));
                end
            end
            if (PcSel) begin
                check("sb_redir_noissue", 32'(imem_en), 32'd0);
                exp_q.delete();
                mfpc = {BrPC[PC_W-1:2], 2'b00};
            end else if (imem_en) begin
                check("sb_addr", 32'(imem_addr), 32'(mfpc));
                exp_q.push_back(mfpc);
                mfpc = mfpc + PC_W'(4);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [PC_W-1:0] t, input int budget);
        logic found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (id_valid && id_pc == t) found = 1'b1;
            else step();
        end
        check("wait_pc", 32'(found), 32'd1);
    endtask

    typedef struct {
        logic [31:0]     br;
        logic [PC_W-1:0] exp_addr;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{br: 32'h0000_0040, exp_addr: 9'h040};
        vt[1] = '{br: 32'h0000_0F0B, exp_addr: 9'h108};
        vt[2] = '{br: 32'h0000_0123, exp_addr: 9'h120};
        vt[3] = '{br: 32'hFFFF_FFFF, exp_addr: 9'h1FC};
        vt[4] = '{br: 32'h0000_0200, exp_addr: 9'h000};
        vt[5] = '{br: 32'h0000_0086, exp_addr: 9'h084};

        reset    = 1'b0;
        PcSel    = 1'b0;
        BrPC     = '0;
        id_ready = 1'b1;
        #3;
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_en", 32'(imem_en), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_pc", 32'(id_pc), 32'd0);
        check("rst_instr", id_instr, 32'd0);
        step();
        step();

        // First fetches and 2-cycle latency
        reset = 1'b1;
        #1;
        check("t1_en", 32'(imem_en), 32'd1);
        check("t1_addr", 32'(imem_addr), 32'd0);
        step();
        check("t1_lat_k1", 32'(id_valid), 32'd0);
        step();
        check("t1_lat_k2", 32'(id_valid), 32'd1);
        check("t1_pc0", 32'(id_pc), 32'h000);
        check("t1_ins0", id_instr, 32'h000);
        step();
        check("t1_pc4", 32'(id_pc), 32'h004);
        check("t1_ins4", id_instr, 32'h004);
        step();
        check("t1_pc8", 32'(id_pc), 32'h008);

        // Backpressure for 3 cycles at 0x010
        wait_pc(9'h010, 10);
        id_ready = 1'b0;
        #1;
        check("t2_stall_en", 32'(imem_en), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("t2_hold_valid", 32'(id_valid), 32'd1);
            check("t2_hold_pc", 32'(id_pc), 32'h010);
            check("t2_hold_instr", id_instr, 32'h010);
            check("t2_hold_en", 32'(imem_en), 32'd0);
        end
        step();
        id_ready = 1'b1;
        #1;
        check("t2_rel_pc", 32'(id_pc), 32'h010);
        check("t2_rel_en", 32'(imem_en), 32'd1);
        step();
        check("t2_next_valid", 32'(id_valid), 32'd1);
        check("t2_next_pc", 32'(id_pc), 32'h014);
        step();
        check("t2_next2_valid", 32'(id_valid), 32'd1);
        check("t2_next2_pc", 32'(id_pc), 32'h018);

        // Redirect with a full pipeline
        repeat (3) step();
        PcSel = 1'b1;
        BrPC  = 32'h0000_0040;
        #1;
        check("t3_redir_en", 32'(imem_en), 32'd0);
        step();
        PcSel = 1'b0;
        #1;
        check("t3_addr", 32'(imem_addr), 32'h040);
        check("t3_en", 32'(imem_en), 32'd1);
        check("t3_flushed", 32'(id_valid), 32'd0);
        step();
        check("t3_stale_drop", 32'(id_valid), 32'd0);
        step();
        check("t3_valid", 32'(id_valid), 32'd1);
        check("t3_pc", 32'(id_pc), 32'h040);

        // Redirect target table, with random backpressure between entries
        foreach (vt[i]) begin
            PcSel = 1'b1;
            BrPC  = vt[i].br;
            step();
            PcSel = 1'b0;
            #1;
            check("tbl_addr", 32'(imem_addr), 32'(vt[i].exp_addr));
            check("tbl_en", 32'(imem_en), 32'd1);
            repeat (6) begin
                id_ready = 1'($urandom_range(0, 1));
                step();
            end
            id_ready = 1'b1;
            repeat (3) step();
        end

        // PC wrap-around at the top of the address space
        PcSel = 1'b1;
        BrPC  = 32'h0000_01FC;
        step();
        PcSel = 1'b0;
        #1;
        check("t4_addr", 32'(imem_addr), 32'h1FC);
        step();
        check("t4_wrap_addr", 32'(imem_addr), 32'h000);
        step();
        check("t4_pc_top", 32'(id_pc), 32'h1FC);
        step();
        check("t4_pc_wrap", 32'(id_pc), 32'h000);
        check("t4_ins_wrap", id_instr, 32'h000);

        // Back-to-back redirects: only the last target is fetched
        PcSel = 1'b1;
        BrPC  = 32'h0000_0020;
        step();
        BrPC = 32'h0000_0080;
        #1;
        check("t5_b2b_en", 32'(imem_en), 32'd0);
        step();
        PcSel = 1'b0;
        #1;
        check("t5_addr", 32'(imem_addr), 32'h080);
        step();
        step();
        check("t5_valid", 32'(id_valid), 32'd1);
        check("t5_pc", 32'(id_pc), 32'h080);

        // Asynchronous reset mid-stream with redirect and stall pending
        repeat (4) step();
        PcSel    = 1'b1;
        BrPC     = 32'h0000_0100;
        id_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("t6_valid", 32'(id_valid), 32'd0);
        check("t6_en", 32'(imem_en), 32'd0);
        check("t6_addr", 32'(imem_addr), 32'd0);
        check("t6_pc", 32'(id_pc), 32'd0);
        step();
        step();
        reset    = 1'b1;
        PcSel    = 1'b0;
        id_ready = 1'b1;
        #1;
        check("t6_restart_addr", 32'(imem_addr), 32'd0);
        check("t6_restart_en", 32'(imem_en), 32'd1);
        step();
        step();
        check("t6_restart_valid", 32'(id_valid), 32'd1);
        check("t6_restart_pc", 32'(id_pc), 32'h000);
        step();
        check("t6_restart_pc4", 32'(id_pc), 32'h004);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
